fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Parametrised instruction-fetch front end for the next-generation core. It owns the PC and issues word reads to the synchronous instruction memory (1-cycle read latency). Returned instructions are buffered with their PC and PC+4 in a prefetch FIFO, handed to decode over a valid/ready handshake, and flushed on branch or jump redirects. It replaces the free-running PC register, PC latch and PC+4 adder of the single-cycle datapath.

Parameters:
XLEN, 32, width of PC and instruction words
ADDR_W, 10, imem word-address width (byte PC bits [ADDR_W+1:2])
RESET_PC, 32'h0, PC loaded on reset (bits [1:0] must be 0)
DEPTH, 4, prefetch FIFO entries (power of 2, >=2)

Ports:
clk  in  1  core clock; all state updates on rising edge
rst  in  1  synchronous active-low reset
halt  in  1  1 = stop issuing new imem reads; buffered entries still drain
redirect_valid  in  1  1 = load PC from redirect_pc and flush
redirect_pc  in  XLEN  redirect target byte address
imem_addr  out  ADDR_W  word address to imem (pc[ADDR_W+1:2])
imem_rd  out  1  read request this cycle
imem_q  in  XLEN  imem data, valid the cycle after imem_rd
out_valid  out  1  FIFO head holds an instruction
out_ready  in  1  decode accepts the head this cycle
out_inst  out  XLEN  instruction at head
out_pc  out  XLEN  PC of head instruction
out_pc4  out  XLEN  out_pc + 4, modulo 2^XLEN

Behaviour:
- Reset (rst==0 at edge): pc=RESET_PC, FIFO empty, inflight=0, state=BOOT. While in reset and the cycle after: imem_rd=0, out_valid=0, out_inst/out_pc/out_pc4=0.
- FSM: BOOT -> RUN unconditionally after 1 cycle. RUN -> STALL when (count+inflight)==DEPTH or halt=1. STALL -> RUN when both conditions clear. Any state -> RUN on redirect_valid, except reset, which has priority over everything.
- Issue (RUN only): imem_rd=1, imem_addr=pc word address, inflight<=1, pc<=pc+4 (wraps at 2^XLEN). Issue condition: (count+inflight)<DEPTH and halt=0. The issue decision uses registered count; a pop in the same cycle frees a slot only from the next cycle.
- Response: the cycle after an issue, {imem_q, issued pc} is pushed at the edge. out_valid rises the following cycle. Request in cycle C gives out_valid in C+2.
- Throughput: 1 instruction/cycle sustained with out_ready=1 when DEPTH>=3.
- Handshake: pop on out_valid && out_ready. out_* are stable while out_valid=1 and out_ready=0. out_ready when out_valid=0 is ignored.
- Redirect (cycle N): FIFO cleared, a response arriving in N+1 for a pre-redirect request is discarded (kill flag), pc<=redirect_pc with bits [1:0] forced to 0, imem_rd=0 in N. First new request is issued in N+1, and out_valid for redirect_pc is asserted in N+3.
- Redirect together with pop: redirect wins and the pop is a no-op. Redirect together with halt: PC is loaded, and issue waits for halt=0.
- Full FIFO: no issue, so overflow is impossible by construction. Empty FIFO: out_valid=0.
- Reset mid-operation: inflight response is discarded and state returns to reset values.
- imem_addr aliases modulo 2^ADDR_W words. No fault is raised.

Optional Feature:
FETCH_BYPASS_EN:
- Defined: when the FIFO is empty and a valid non-killed response arrives, out_* present imem_q and its PC combinationally in that same cycle with out_valid=1. If out_ready=1, the entry is consumed and not pushed; otherwise it is pushed.
- Effect: request in C gives out_valid in C+1, and redirect in N gives first out_valid in N+2.
- Undefined: all outputs come from the FIFO only, with the latencies stated in Behaviour.

Test Plan:
1. Reset release, RESET_PC=0, out_ready=1, imem returns addr*16 -> imem_addr 0,1,2,3 on consecutive cycles; out_pc 0,4,8 one per cycle starting 2 cycles after first imem_rd; out_pc4=out_pc+4.
2. out_ready=0 for 10 cycles -> imem_rd stops after DEPTH entries are buffered (count+inflight=4); out_* held constant; on release, 4 entries drain in order with no loss or duplication.
3. redirect_valid with redirect_pc=0x103 while the FIFO holds 3 entries and one request is in flight -> FIFO emptied, stale response dropped, next imem_addr=0x40, next out_pc=0x100 at N+3 (N+2 with FETCH_BYPASS_EN).
4. halt=1 for 5 cycles with out_ready=1 -> no imem_rd, buffered entries drain, out_valid falls; halt=0 resumes at the correct next PC.
5. PC wrap: redirect to 0xFFFFFFFC -> out_pc 0xFFFFFFFC then 0x00000000; out_pc4 of the first is 0x0.
6. rst asserted low mid-stream with an entry in flight -> next cycle all outputs 0, pc=RESET_PC; stale imem_q is never delivered.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: control inputs (halt/redirect), the instruction
// memory request/response pair and the decode-side valid/ready handshake.
// "slave" is the fetch unit's view, "master" is the surrounding core/bench.
interface fetch_unit_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 10
);
    logic              halt;
    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_pc;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_rd;
    logic [XLEN-1:0]   imem_q;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_inst;
    logic [XLEN-1:0]   out_pc;
    logic [XLEN-1:0]   out_pc4;

    modport master (
        output halt, redirect_valid, redirect_pc, imem_q, out_ready,
        input  imem_addr, imem_rd, out_valid, out_inst, out_pc, out_pc4
    );

    modport slave (
        input  halt, redirect_valid, redirect_pc, imem_q, out_ready,
        output imem_addr, imem_rd, out_valid, out_inst, out_pc, out_pc4
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues one word read per cycle to
// a 1-cycle-latency instruction memory, buffers {inst, pc} in a prefetch FIFO
// and hands entries to decode over valid/ready. Redirects flush everything.
// Optional feature macro: FETCH_BYPASS_EN (present a response directly when
// the FIFO is empty, saving one cycle of latency).
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              ADDR_W   = 10,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 4
) (
    input  logic       clk,
    input  logic       rst,
    fetch_unit_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [XLEN-1:0]  STEP    = XLEN'(4);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t            state_reg;
    logic [XLEN-1:0]   pc_reg;
    logic [XLEN-1:0]   resp_pc_reg;
    logic              inflight_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [XLEN-1:0]   inst_mem [DEPTH];
    logic [XLEN-1:0]   pc_mem   [DEPTH];

    logic [CNT_W-1:0]  occupancy;
    logic              has_room;
    logic              issue;
    logic              resp_valid;
    logic              fifo_empty;
    logic [XLEN-1:0]   redirect_target;
    logic              sel_bypass;
    logic              push;
    logic              pop;
    logic              out_valid_c;
    logic [XLEN-1:0]   out_inst_c;
    logic [XLEN-1:0]   out_pc_c;

    // Buffered entries plus the one in flight must never exceed DEPTH, so a
    // response always has a slot and overflow cannot happen.
    assign occupancy  = count_reg + CNT_W'(inflight_reg);
    assign has_room   = occupancy < DEPTH_C;
    assign issue      = rst && !bus.redirect_valid && (state_reg == RUN) && has_room && !bus.halt;
    // A response returning in the redirect (or reset) cycle belongs to the old
    // stream and is dropped rather than pushed.
    assign resp_valid = rst && inflight_reg && !bus.redirect_valid;
    assign fifo_empty = (count_reg == '0);
    assign redirect_target = bus.redirect_pc & ~XLEN'(3);

    assign bus.imem_rd   = issue;
    assign bus.imem_addr = pc_reg[ADDR_W+1:2];
    assign bus.out_valid = out_valid_c;
    assign bus.out_inst  = out_inst_c;
    assign bus.out_pc    = out_pc_c;
    assign bus.out_pc4   = out_valid_c ? (out_pc_c + STEP) : '0;

    // Head selection (FIFO head or bypassed response) and push/pop decisions.
    always_comb begin
        sel_bypass = 1'b0;
`ifdef FETCH_BYPASS_EN
        sel_bypass = resp_valid && fifo_empty;
`endif
        out_valid_c = 1'b0;
        out_inst_c  = '0;
        out_pc_c    = '0;
        if (rst) begin
            if (!fifo_empty) begin
                out_valid_c = 1'b1;
                out_inst_c  = inst_mem[rd_ptr_reg];
                out_pc_c    = pc_mem[rd_ptr_reg];
            end else if (sel_bypass) begin
                out_valid_c = 1'b1;
                out_inst_c  = bus.imem_q;
                out_pc_c    = resp_pc_reg;
            end
        end
        pop  = rst && !bus.redirect_valid && !fifo_empty && bus.out_ready;
        push = resp_valid && !(sel_bypass && bus.out_ready);
    end

    // Fetch state machine: BOOT for one cycle, then RUN/STALL by room and halt.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= BOOT;
        end else if (bus.redirect_valid) begin
            state_reg <= RUN;
        end else begin
            case (state_reg)
                BOOT:    state_reg <= RUN;
                RUN:     if (!has_room || bus.halt) state_reg <= STALL;
                STALL:   if (has_room && !bus.halt) state_reg <= RUN;
                default: state_reg <= BOOT;
            endcase
        end
    end

    // PC, in-flight tracking and FIFO pointers/count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_reg       <= RESET_PC;
            resp_pc_reg  <= '0;
            inflight_reg <= 1'b0;
            count_reg    <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
        end else begin
            inflight_reg <= issue;
            if (issue) begin
                resp_pc_reg <= pc_reg;
            end
            if (bus.redirect_valid) begin
                pc_reg     <= redirect_target;
                count_reg  <= '0;
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
            end else begin
                if (issue) begin
                    pc_reg <= pc_reg + STEP;
                end
                if (push) begin
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                end
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + 1'b1;
                end
                count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // FIFO storage write port; contents need no reset since count gates reads.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr_reg] <= bus.imem_q;
            pc_mem[wr_ptr_reg]   <= resp_pc_reg;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal
// expectations followed by randomized traffic checked every cycle against a
// queue-based behavioural model. Honours FETCH_BYPASS_EN if defined.
`timescale 1ns/1ps
module tb_fetch_unit;
    localparam int          XLEN     = 32;
    localparam int          ADDR_W   = 10;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;
`ifdef FETCH_BYPASS_EN
    localparam int LAT = 1;
    localparam bit BYP = 1'b1;
`else
    localparam int LAT = 2;
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    fetch_unit_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus();

    fetch_unit #(
        .XLEN(XLEN), .ADDR_W(ADDR_W), .RESET_PC(RESET_PC), .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit started = 1'b0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Instruction memory contents: word address * 16.
    function automatic logic [31:0] mem_word(logic [31:0] pc);
        return {18'b0, pc[11:2], 4'b0};
    endfunction

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc;
    logic [31:0] m_infl_pc;
    bit          m_infl;
    bit          m_run_ok;
    bit          m_boot;
    logic [31:0] q_inst[$];
    logic [31:0] q_pc[$];

    function automatic void model_eval(output bit e_rd, output logic [9:0] e_addr,
                                       output bit e_valid, output logic [31:0] e_inst,
                                       output logic [31:0] e_pc, output bit e_byp);
        int occ;
        occ     = q_pc.size() + int'(m_infl);
        e_rd    = (rst === 1'b1) && !bus.redirect_valid && m_run_ok && !bus.halt && (occ < DEPTH);
        e_addr  = m_pc[11:2];
        e_byp   = 1'b0;
        e_valid = 1'b0;
        e_inst  = '0;
        e_pc    = '0;
        if (rst === 1'b1) begin
            if (q_pc.size() > 0) begin
                e_valid = 1'b1;
                e_inst  = q_inst[0];
                e_pc    = q_pc[0];
            end else if (BYP && m_infl && !bus.redirect_valid) begin
                e_byp   = 1'b1;
                e_valid = 1'b1;
                e_inst  = mem_word(m_infl_pc);
                e_pc    = m_infl_pc;
            end
        end
    endfunction

    always @(posedge clk) begin
        bit e_rd, e_valid, e_byp, nrun;
        logic [9:0] e_addr;
        logic [31:0] e_inst, e_pc;
        model_eval(e_rd, e_addr, e_valid, e_inst, e_pc, e_byp);
        if (rst !== 1'b1) begin
            m_pc      = RESET_PC;
            m_infl    = 1'b0;
            m_infl_pc = '0;
            m_run_ok  = 1'b0;
            m_boot    = 1'b1;
            q_inst.delete();
            q_pc.delete();
        end else begin
            nrun = bus.redirect_valid || m_boot ||
                   (!bus.halt && (q_pc.size() + int'(m_infl)) < DEPTH);
            if (bus.redirect_valid) begin
                q_inst.delete();
                q_pc.delete();
            end else begin
                if (e_valid && bus.out_ready && q_pc.size() > 0) begin
                    void'(q_inst.pop_front());
                    void'(q_pc.pop_front());
                end
                if (m_infl && !(e_byp && bus.out_ready)) begin
                    q_inst.push_back(mem_word(m_infl_pc));
                    q_pc.push_back(m_infl_pc);
                end
            end
            m_infl = e_rd;
            if (e_rd) m_infl_pc = m_pc;
            if (bus.redirect_valid) m_pc = bus.redirect_pc & 32'hFFFF_FFFC;
            else if (e_rd)          m_pc = m_pc + 32'd4;
            m_run_ok = nrun;
            m_boot   = 1'b0;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        bit e_rd, e_valid, e_byp;
        logic [9:0] e_addr;
        logic [31:0] e_inst, e_pc;
        if (started) begin
            model_eval(e_rd, e_addr, e_valid, e_inst, e_pc, e_byp);
            check("imem_rd", 32'(bus.imem_rd), 32'(e_rd));
            if (e_rd) check("imem_addr", 32'(bus.imem_addr), 32'(e_addr));
            check("out_valid", 32'(bus.out_valid), 32'(e_valid));
            if (e_valid || rst !== 1'b1 || m_boot) begin
                check("out_inst", bus.out_inst, e_inst);
                check("out_pc", bus.out_pc, e_pc);
                check("out_pc4", bus.out_pc4, e_valid ? e_pc + 32'd4 : 32'd0);
            end
        end
    end

    // ---------------- stimulus ----------------
    logic        s_rd, s_valid;
    logic [9:0]  s_addr;
    logic [31:0] s_inst, s_pc, s_pc4;

    task automatic cycle(input logic r, input logic h, input logic rv,
                         input logic [31:0] rp, input logic rdy);
        rst                = r;
        bus.halt           = h;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rp;
        bus.out_ready      = rdy;
        @(negedge clk);
        s_rd    = bus.imem_rd;
        s_addr  = bus.imem_addr;
        s_valid = bus.out_valid;
        s_inst  = bus.out_inst;
        s_pc    = bus.out_pc;
        s_pc4   = bus.out_pc4;
        @(posedge clk);
        #1;
        bus.imem_q = s_rd ? {18'b0, s_addr, 4'b0} : $urandom;
        started = 1'b1;
    endtask

    logic        r_rst, r_halt, r_rv, r_rdy;
    logic [31:0] r_pc;

    initial begin
        rst = 1'b0;
        bus.halt = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.out_ready = 1'b1;
        bus.imem_q = '0;

        // Reset state.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
            if (i > 0) begin
                check("rst_rd", 32'(s_rd), 32'd0);
                check("rst_valid", 32'(s_valid), 32'd0);
                check("rst_pc", s_pc, 32'd0);
            end
        end

        // Sequential fetch from RESET_PC.
        for (int k = 0; k < 6; k++) begin
            cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
            if (k == 0) begin
                check("boot_rd", 32'(s_rd), 32'd0);
                check("boot_valid", 32'(s_valid), 32'd0);
                check("boot_inst", s_inst, 32'd0);
            end
            if (k >= 1 && k <= 4) begin
                check("seq_rd", 32'(s_rd), 32'd1);
                check("seq_addr", 32'(s_addr), 32'(k - 1));
            end
            if (k >= 1 + LAT) begin
                check("seq_pc", s_pc, 32'((k - 1 - LAT) * 4));
                check("seq_pc4", s_pc4, 32'((k - LAT) * 4));
            end
        end

        // Back-pressure until the FIFO plus in-flight slot is full.
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        check("full_rd", 32'(s_rd), 32'd0);
        check("full_valid", 32'(s_valid), 32'd1);
        // Free one slot so three entries are buffered with one request in flight.
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

        // Redirect to an unaligned target.
        cycle(1'b1, 1'b0, 1'b1, 32'h0000_0103, 1'b0);
        check("redir_rd", 32'(s_rd), 32'd0);
        for (int j = 1; j <= 6; j++) begin
            cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
            check("redir_rd_n", 32'(s_rd), 32'd1);
            check("redir_addr", 32'(s_addr), 32'(10'h40 + j - 1));
            if (j == LAT) check("redir_early_valid", 32'(s_valid), 32'd0);
            if (j == 1 + LAT) begin
                check("redir_valid", 32'(s_valid), 32'd1);
                check("redir_pc", s_pc, 32'h0000_0100);
                check("redir_inst", s_inst, 32'h0000_0400);
                check("redir_pc4", s_pc4, 32'h0000_0104);
            end
        end

        // Halt: no issue, buffered entries drain.
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
            check("halt_rd", 32'(s_rd), 32'd0);
        end
        check("halt_drained", 32'(s_valid), 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        check("resume_bubble", 32'(s_rd), 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        check("resume_rd", 32'(s_rd), 32'd1);
        check("resume_addr", 32'(s_addr), 32'h46);
        for (int j = 1; j <= LAT; j++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        check("resume_pc", s_pc, 32'h0000_0118);

        // PC wrap.
        cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        for (int j = 1; j <= 4; j++) begin
            cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
            if (j == 1) check("wrap_addr0", 32'(s_addr), 32'h3FF);
            if (j == 2) check("wrap_addr1", 32'(s_addr), 32'h000);
            if (j == 1 + LAT) begin
                check("wrap_pc0", s_pc, 32'hFFFF_FFFC);
                check("wrap_pc4_0", s_pc4, 32'h0000_0000);
                check("wrap_inst0", s_inst, 32'h0000_3FF0);
            end
            if (j == 2 + LAT) begin
                check("wrap_pc1", s_pc, 32'h0000_0000);
                check("wrap_pc4_1", s_pc4, 32'h0000_0004);
            end
        end

        // Reset mid-stream with a request in flight.
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check("mrst_rd", 32'(s_rd), 32'd0);
        check("mrst_valid", 32'(s_valid), 32'd0);
        check("mrst_inst", s_inst, 32'd0);
        check("mrst_pc4", s_pc4, 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        check("mrst_after_valid", 32'(s_valid), 32'd0);
        check("mrst_after_pc", s_pc, 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        check("mrst_first_rd", 32'(s_rd), 32'd1);
        check("mrst_first_addr", 32'(s_addr), 32'd0);
        for (int j = 1; j <= LAT; j++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        check("mrst_first_valid", 32'(s_valid), 32'd1);
        check("mrst_first_pc", s_pc, 32'd0);

        // Randomized traffic, checked by the per-cycle compare.
        for (int i = 0; i < 3000; i++) begin
            r_rst  = ($urandom_range(0, 199) != 0);
            r_halt = ($urandom_range(0, 99) < 15);
            r_rv   = ($urandom_range(0, 99) < 4);
            r_pc   = $urandom;
            r_rdy  = ($urandom_range(0, 99) < 65);
            cycle(r_rst, r_halt, r_rv, r_pc, r_rdy);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
